// File: rtl/ckemon.sv
// ckemon -- clock-enable stream monitor.
// Measures the rising-edge-to-rising-edge period of cke_in in clk cycles,
// checks it against T +/- TOL, declares lock after LOCK_N consecutive good
// periods and reports loss on a bad period (while locked) or on a timeout.
// Optional feature macro: CKEMON_DUTY_EN -- adds a high-time counter, reports
// it on high_time and includes the duty window in the tolerance decision.
module ckemon #(
   parameter int T      = 'd50000000,
   parameter int TOL    = 'd2,
   parameter int LOCK_N = 'd4,
   localparam int W     = $clog2(T + TOL + 2)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         cke_in,
   output logic [W-1:0] period,
   output logic [W-1:0] high_time,
   output logic         meas,
   output logic         lock,
   output logic         lost
);

   // Good-period run counter only needs to reach LOCK_N-1.
   localparam int CW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;

   localparam logic [W-1:0]  C_SAT       = W'(T + TOL + 1);
   localparam logic [W-1:0]  C_PER_MIN   = W'(T - TOL);
   localparam logic [W-1:0]  C_PER_MAX   = W'(T + TOL);
   localparam logic [CW-1:0] C_GOOD_LAST = CW'(LOCK_N - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MEAS   = 2'd1,
      S_LOCKED = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic          r_cke_d;
   logic [W-1:0]  r_cnt;
   logic [CW-1:0] r_good;
   logic [CW-1:0] w_good_next;
   logic          r_pend;
   logic          w_pend_next;
   logic          r_meas;
   logic          w_meas_next;
   logic          r_lost;
   logic          w_lost_next;
   logic [W-1:0]  r_period;

   logic          w_edge;
   logic          w_sat;
   logic          w_capture;
   logic          w_per_ok;
   logic          w_duty_ok;
   logic          w_tol_ok;

   assign w_edge    = cke_in & ~r_cke_d;
   assign w_sat     = (r_cnt == C_SAT);
   assign w_capture = w_edge & (r_state != S_IDLE);
   assign w_per_ok  = (r_cnt >= C_PER_MIN) && (r_cnt <= C_PER_MAX);
   assign w_tol_ok  = w_per_ok & w_duty_ok;

   // Edge history and cycle counter: counter restarts at 1 after an edge
   // and sticks at the timeout value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cke_d <= 1'b0;
         r_cnt   <= '0;
      end else if (ena) begin
         r_cke_d <= cke_in;
         if (w_edge) begin
            r_cnt <= W'(1);
         end else if (!w_sat) begin
            r_cnt <= r_cnt + W'(1);
         end
      end
   end

`ifdef CKEMON_DUTY_EN
   localparam logic [W-1:0] C_HI_MIN = W'(T / 2 - TOL);
   localparam logic [W-1:0] C_HI_MAX = W'(T / 2 + TOL + 1);

   logic [W-1:0] r_hi;
   logic [W-1:0] r_high_time;

   assign w_duty_ok = (r_hi >= C_HI_MIN) && (r_hi <= C_HI_MAX);
   assign high_time = r_high_time;

   // High counter: the edge cycle itself counts as the first high cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
      end else if (ena) begin
         if (w_edge) begin
            r_hi <= W'(1);
         end else if (cke_in && (r_hi != C_SAT)) begin
            r_hi <= r_hi + W'(1);
         end
      end
   end

   // High-time result is latched together with the period.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_high_time <= '0;
      end else if (ena && w_capture) begin
         r_high_time <= r_hi;
      end
   end
`else
   assign w_duty_ok = 1'b1;
   assign high_time = '0;
`endif

   // Period result: the counter value on an edge is the distance from the
   // previous edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period <= '0;
      end else if (ena && w_capture) begin
         r_period <= r_cnt;
      end
   end

   // State register plus the one-cycle event pulses; pulses die whenever
   // the monitor is paused.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_good  <= '0;
         r_pend  <= 1'b0;
         r_meas  <= 1'b0;
         r_lost  <= 1'b0;
      end else if (ena) begin
         r_state <= w_state_next;
         r_good  <= w_good_next;
         r_pend  <= w_pend_next;
         r_meas  <= w_meas_next;
         r_lost  <= w_lost_next;
      end else begin
         r_meas  <= 1'b0;
         r_lost  <= 1'b0;
      end
   end

   // Next-state logic. Lock is granted on the cycle the final good
   // measurement is published (r_pend), so lock rises one cycle after that
   // meas pulse; loss is decided directly on the edge so lost coincides
   // with meas. An edge always wins over a simultaneous timeout.
   always_comb begin
      w_state_next = r_state;
      w_good_next  = r_good;
      w_pend_next  = r_pend;
      w_meas_next  = 1'b0;
      w_lost_next  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_edge) begin
               w_state_next = S_MEAS;
               w_good_next  = '0;
               w_pend_next  = 1'b0;
            end
         end
         S_MEAS: begin
            if (w_edge) begin
               w_meas_next = 1'b1;
               if (!w_tol_ok) begin
                  w_good_next = '0;
               end else if (r_good == C_GOOD_LAST) begin
                  w_good_next = '0;
                  w_pend_next = 1'b1;
               end else begin
                  w_good_next = r_good + CW'(1);
               end
            end else if (r_pend) begin
               w_state_next = S_LOCKED;
               w_pend_next  = 1'b0;
            end else if (w_sat) begin
               w_state_next = S_IDLE;
               w_good_next  = '0;
               w_lost_next  = 1'b1;
            end
         end
         S_LOCKED: begin
            if (w_edge) begin
               w_meas_next = 1'b1;
               if (!w_tol_ok) begin
                  w_state_next = S_MEAS;
                  w_good_next  = '0;
                  w_lost_next  = 1'b1;
               end
            end else if (w_sat) begin
               w_state_next = S_IDLE;
               w_good_next  = '0;
               w_lost_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_good_next  = '0;
            w_pend_next  = 1'b0;
         end
      endcase
   end

   assign period = r_period;
   assign meas   = r_meas;
   assign lost   = r_lost;
   assign lock   = (r_state == S_LOCKED);

endmodule

// File: tb/tb_ckemon.sv
// tb_ckemon -- self-checking bench for ckemon (T=10, TOL=1, LOCK_N=3).
// Every cycle is compared against a reference model that works from the
// sample history between rising edges; a vector table and hand sequences
// cover the lock/loss/timeout/pause/reset corner cases.
// Honours CKEMON_DUTY_EN the same way the design does.
module tb_ckemon;

   localparam int T      = 10;
   localparam int TOL    = 1;
   localparam int LOCK_N = 3;
   localparam int W      = $clog2(T + TOL + 2);
   localparam int SAT    = T + TOL + 1;

`ifdef CKEMON_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ena = 1'b0;
   logic         cke_in = 1'b0;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         meas;
   logic         lock;
   logic         lost;

   ckemon #(.T(T), .TOL(TOL), .LOCK_N(LOCK_N)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .cke_in    (cke_in),
      .period    (period),
      .high_time (high_time),
      .meas      (meas),
      .lock      (lock),
      .lost      (lost)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int n_meas = 0;
   int n_lost = 0;
   int lost_at = -1;

   // ---------------- reference model ----------------
   // m_hist holds the enabled samples since the last rising edge (edge
   // cycle first), so period = its length and high time = its sum.
   bit m_hist[$];
   bit m_prev;
   int m_phase;        // 0 no edge yet, 1 measuring, 2 locked
   int m_good;
   bit m_pend;         // lock granted on the next enabled cycle
   int m_period;
   int m_high;
   bit m_meas;
   bit m_lost;

   function automatic bit in_tol(input int p, input int h);
      bit ok;
      ok = (p >= T - TOL) && (p <= T + TOL);
      if (DUTY) ok = ok && (h >= T / 2 - TOL) && (h <= T / 2 + TOL + 1);
      return ok;
   endfunction

   function automatic void model_step(input bit r, input bit e, input bit c);
      int p;
      int h;
      if (r) begin
         m_hist.delete();
         m_prev = 1'b0; m_phase = 0; m_good = 0; m_pend = 1'b0;
         m_period = 0; m_high = 0; m_meas = 1'b0; m_lost = 1'b0;
         return;
      end
      m_meas = 1'b0;
      m_lost = 1'b0;
      if (!e) return;
      if (m_pend) begin
         m_phase = 2;
         m_pend  = 1'b0;
      end
      if (c && !m_prev) begin
         if (m_phase != 0) begin
            p = m_hist.size();
            h = 0;
            foreach (m_hist[i]) h += int'(m_hist[i]);
            m_meas   = 1'b1;
            m_period = p;
            m_high   = DUTY ? h : 0;
            if (!in_tol(p, h)) begin
               if (m_phase == 2) m_lost = 1'b1;
               m_phase = 1;
               m_good  = 0;
            end else if (m_phase == 1) begin
               m_good++;
               if (m_good == LOCK_N) begin
                  m_good = 0;
                  m_pend = 1'b1;
               end
            end
         end else begin
            m_phase = 1;
            m_good  = 0;
         end
         m_hist.delete();
         m_hist.push_back(1'b1);
      end else begin
         if (m_phase != 0 && m_hist.size() == SAT) begin
            m_phase = 0; m_good = 0; m_pend = 1'b0; m_lost = 1'b1;
         end
         if (m_hist.size() <= SAT) m_hist.push_back(c);
      end
      m_prev = c;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive, let the DUT sample, compare everything #1 later.
   task automatic step(input bit r, input bit e, input bit c);
      rst = r; ena = e; cke_in = c;
      @(posedge clk);
      #1;
      model_step(r, e, c);
      chk("meas",      int'(meas),      int'(m_meas));
      chk("lost",      int'(lost),      int'(m_lost));
      chk("lock",      int'(lock),      (m_phase == 2) ? 1 : 0);
      chk("period",    int'(period),    m_period);
      chk("high_time", int'(high_time), m_high);
      if (meas) n_meas++;
      if (lost) begin
         n_lost++;
         lost_at = cyc;
      end
      cyc++;
   endtask

   // Cycles [from, to) of a period of length p that is high for its first h.
   task automatic send_part(input int p, input int h, input int from, input int to);
      for (int i = from; i < to; i++) step(1'b0, 1'b1, i < h);
   endtask

   // Reset, then four ideal periods: lock is up from the cycle after the
   // fourth edge's meas.
   task automatic lock_up();
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) send_part(10, 6, 0, 10);
   endtask

   typedef struct {
      int p;
      int h;
      int exp_meas;
      int exp_period;
      int exp_high;
      int exp_lost;
      int exp_lock;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int s;
      // p, h, meas count, period, high_time, lost count, lock afterwards
      tbl[0] = '{10, 6, 1, 10, DUTY ? 6 : 0, 0, 1};
      tbl[1] = '{ 9, 4, 1,  9, DUTY ? 4 : 0, 0, 1};
      tbl[2] = '{11, 7, 1, 11, DUTY ? 7 : 0, 0, 1};
      tbl[3] = '{ 8, 4, 1,  8, DUTY ? 4 : 0, 1, 0};
      tbl[4] = '{12, 6, 1, 12, DUTY ? 6 : 0, 1, 0};
      tbl[5] = '{13, 6, 0, 10, DUTY ? 6 : 0, 1, 0};
      tbl[6] = '{10, 9, 1, 10, DUTY ? 9 : 0, DUTY ? 1 : 0, DUTY ? 0 : 1};
      tbl[7] = '{10, 3, 1, 10, DUTY ? 3 : 0, DUTY ? 1 : 0, DUTY ? 0 : 1};

      // Reset state.
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("rst_period", int'(period), 0);
      chk("rst_lock",   int'(lock),   0);
      chk("rst_meas",   int'(meas),   0);

      // Ideal stream: first meas carries 10, lock one cycle after third meas.
      n_meas = 0;
      send_part(10, 6, 0, 10);
      chk("first_edge_no_meas", n_meas, 0);
      step(1'b0, 1'b1, 1'b1);
      chk("first_meas", int'(meas), 1);
      chk("first_period", int'(period), 10);
      chk("first_high", int'(high_time), DUTY ? 6 : 0);
      send_part(10, 6, 1, 10);
      send_part(10, 6, 0, 10);
      step(1'b0, 1'b1, 1'b1);
      chk("third_meas", int'(meas), 1);
      chk("lock_not_yet", int'(lock), 0);
      step(1'b0, 1'b1, 1'b1);
      chk("lock_rise", int'(lock), 1);
      $display("seq ideal: period=%0d high=%0d lock=%0d", period, high_time, lock);

      // Table: one record period after lock, closed by a trailing edge.
      foreach (tbl[v]) begin
         lock_up();
         send_part(tbl[v].p, tbl[v].h, 0, 1);
         n_meas = 0;
         n_lost = 0;
         send_part(tbl[v].p, tbl[v].h, 1, tbl[v].p);
         send_part(10, 6, 0, 2);
         chk("vec_meas",   n_meas,            tbl[v].exp_meas);
         chk("vec_period", int'(period),      tbl[v].exp_period);
         chk("vec_high",   int'(high_time),   tbl[v].exp_high);
         chk("vec_lost",   n_lost,            tbl[v].exp_lost);
         chk("vec_lock",   int'(lock),        tbl[v].exp_lock);
         $display("vec %0d: p=%0d h=%0d -> meas=%0d period=%0d lost=%0d lock=%0d",
                  v, tbl[v].p, tbl[v].h, n_meas, period, n_lost, lock);
      end

      // Relock after a bad period needs three more good periods.
      lock_up();
      send_part(12, 6, 0, 12);
      step(1'b0, 1'b1, 1'b1);
      chk("bad_lost", int'(lost), 1);
      send_part(10, 6, 1, 10);
      send_part(10, 6, 0, 10);
      send_part(10, 6, 0, 10);
      step(1'b0, 1'b1, 1'b1);
      chk("relock_pending", int'(lock), 0);
      step(1'b0, 1'b1, 1'b1);
      chk("relock", int'(lock), 1);
      $display("seq relock: lock=%0d", lock);

      // Stuck low while locked: one lost, 12 cycles after the last edge.
      lock_up();
      step(1'b0, 1'b1, 1'b1);
      s = cyc - 1;
      n_lost = 0;
      lost_at = -1;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
      chk("tmo_count", n_lost, 1);
      chk("tmo_delay", lost_at - s, 12);
      chk("tmo_lock", int'(lock), 0);
      chk("tmo_period", int'(period), 10);
      n_meas = 0;
      send_part(10, 6, 0, 10);
      chk("tmo_idle_no_meas", n_meas, 0);
      $display("seq timeout: lost after %0d cycles, period=%0d", lost_at - s, period);

      // Pause for 20 cycles mid-period.
      lock_up();
      step(1'b0, 1'b1, 1'b1);
      n_meas = 0;
      n_lost = 0;
      send_part(10, 6, 1, 4);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("pause_no_meas", n_meas, 0);
      chk("pause_no_lost", n_lost, 0);
      send_part(10, 6, 4, 10);
      step(1'b0, 1'b1, 1'b1);
      chk("pause_period", int'(period), 10);
      chk("pause_high", int'(high_time), DUTY ? 6 : 0);
      chk("pause_lock", int'(lock), 1);
      $display("seq pause: period=%0d lock=%0d", period, lock);

      // Reset (with ena low) while locked.
      lock_up();
      send_part(10, 6, 0, 3);
      step(1'b1, 1'b0, 1'b1);
      chk("rst_lock2",   int'(lock),      0);
      chk("rst_period2", int'(period),    0);
      chk("rst_high2",   int'(high_time), 0);
      chk("rst_meas2",   int'(meas),      0);
      chk("rst_lost2",   int'(lost),      0);
      step(1'b0, 1'b1, 1'b1);
      chk("rst_first_edge", int'(meas), 0);
      send_part(10, 6, 1, 10);
      step(1'b0, 1'b1, 1'b1);
      chk("rst_second_edge", int'(meas), 1);
      $display("seq reset: first edge after reset gave no meas");

      // Randomised streams with pauses and rare resets.
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 300; k++) begin
         int p;
         int h;
         if ($urandom_range(0, 1) == 1) begin
            p = $urandom_range(T - TOL, T + TOL);
            h = $urandom_range(T / 2 - TOL, T / 2 + TOL + 1);
         end else begin
            p = $urandom_range(3, 15);
            h = $urandom_range(1, p - 1);
         end
         for (int i = 0; i < p; i++)
            step($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0, i < h);
      end
      $display("random: %0d cycles", cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
